// File: rtl/press_classifier.sv
// press_classifier: turns debounced rising/falling pulses into short, double and long press events.
// Define PRESS_REPEAT_EN to enable auto-repeat pulses while a long press is held.
package pipeline_types;
   typedef struct packed {
      logic rising;
      logic falling;
   } control_path_t;
endpackage

module press_classifier
   import pipeline_types::*;
#(
   parameter int LONG_PRESS_CYCLES = 1000,
   parameter int DOUBLE_GAP_CYCLES = 300,
   parameter int REPEAT_CYCLES     = 200
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  control_path_t i_control,
   output logic          o_short_press,
   output logic          o_double_press,
   output logic          o_long_press,
   output logic          o_held,
   output logic          o_repeat,
   output logic          o_busy
);

   localparam int MAX_LG  = (LONG_PRESS_CYCLES > DOUBLE_GAP_CYCLES) ? LONG_PRESS_CYCLES
                                                                    : DOUBLE_GAP_CYCLES;
   localparam int MAX_ALL = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_ALL + 1);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_CYCLES - 1);

   if (LONG_PRESS_CYCLES < 2 || DOUBLE_GAP_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("press_classifier: all cycle parameters must be >= 2");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS1,
      ST_WAIT_GAP,
      ST_PRESS2,
      ST_LONG_HELD
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             short_q, short_d;
   logic             double_q, double_d;
   logic             long_q, long_d;
   logic             held_q, held_d;
   logic             busy_q, busy_d;
   logic             rise, fall;

`ifdef PRESS_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
   logic repeat_q, repeat_d;
`endif

   // Coincident edges carry no usable direction, so both are dropped.
   assign rise = i_control.rising & ~i_control.falling;
   assign fall = i_control.falling & ~i_control.rising;

   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      short_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
`ifdef PRESS_REPEAT_EN
      repeat_d = 1'b0;
`endif

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rise) state_d = ST_PRESS1;
         end
         ST_PRESS1: begin
            if (fall) begin
               state_d = ST_WAIT_GAP;
            end else if (cnt_q == LONG_LAST) begin
               state_d = ST_LONG_HELD;
               long_d  = 1'b1;
            end
         end
         ST_WAIT_GAP: begin
            if (rise) begin
               state_d = ST_PRESS2;
            end else if (cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
               short_d = 1'b1;
            end
         end
         ST_PRESS2: begin
            cnt_d = '0;
            if (fall) begin
               state_d  = ST_IDLE;
               double_d = 1'b1;
            end
         end
         ST_LONG_HELD: begin
`ifdef PRESS_REPEAT_EN
            if (fall) begin
               state_d = ST_IDLE;
            end else if (cnt_q == REPEAT_LAST) begin
               cnt_d    = '0;
               repeat_d = 1'b1;
            end
`else
            cnt_d = '0;
            if (fall) state_d = ST_IDLE;
`endif
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (state_d != state_q) cnt_d = '0;

      held_d = (state_d == ST_LONG_HELD);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         short_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
         held_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep all state updates on the same edge.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         short_q  <= short_d;
         double_q <= double_d;
         long_q   <= long_d;
         held_q   <= held_d;
         busy_q   <= busy_d;
      end
   end

`ifdef PRESS_REPEAT_EN
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) repeat_q <= 1'b0;
      else            repeat_q <= repeat_d;
   end
   assign o_repeat = repeat_q;
`else
   assign o_repeat = 1'b0;
`endif

   assign o_short_press  = short_q;
   assign o_double_press = double_q;
   assign o_long_press   = long_q;
   assign o_held         = held_q;
   assign o_busy         = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier: timestamp-based gesture model checked every cycle,
// directed scenarios pinned to literal cycle numbers, then randomized gestures.
module tb_press_classifier;
   import pipeline_types::*;

   localparam int L = 1000;
   localparam int G = 300;
   localparam int R = 200;
`ifdef PRESS_REPEAT_EN
   localparam bit REPEAT_EN = 1'b1;
`else
   localparam bit REPEAT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   control_path_t ctrl;
   logic          o_short_press, o_double_press, o_long_press, o_held, o_repeat, o_busy;

   press_classifier #(
      .LONG_PRESS_CYCLES(L),
      .DOUBLE_GAP_CYCLES(G),
      .REPEAT_CYCLES    (R)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_control     (ctrl),
      .o_short_press (o_short_press),
      .o_double_press(o_double_press),
      .o_long_press  (o_long_press),
      .o_held        (o_held),
      .o_repeat      (o_repeat),
      .o_busy        (o_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Gesture model: what the user is doing, plus the cycle the current phase started.
   typedef enum {G_IDLE, G_FIRST_DOWN, G_GAP, G_SECOND_DOWN, G_HELD} gesture_e;
   gesture_e g_mode = G_IDLE;
   int       g_t0   = 0;

   bit exp_short = 0, exp_double = 0, exp_long = 0, exp_held = 0, exp_repeat = 0, exp_busy = 0;
   bit nxt_short, nxt_double, nxt_long, nxt_held, nxt_repeat, nxt_busy;

   task automatic model_cycle(input bit r, input bit f, input bit rv, input int n);
      bit rq, fq;
      rq = r & ~f;
      fq = f & ~r;
      nxt_short = 0; nxt_double = 0; nxt_long = 0; nxt_repeat = 0;
      if (!rv) begin
         g_mode = G_IDLE;
      end else begin
         case (g_mode)
            G_IDLE: if (rq) begin g_mode = G_FIRST_DOWN; g_t0 = n; end
            G_FIRST_DOWN:
               if (fq) begin g_mode = G_GAP; g_t0 = n; end
               else if (n - g_t0 == L) begin g_mode = G_HELD; g_t0 = n; nxt_long = 1; end
            G_GAP:
               if (rq) g_mode = G_SECOND_DOWN;
               else if (n - g_t0 == G) begin g_mode = G_IDLE; nxt_short = 1; end
            G_SECOND_DOWN: if (fq) begin g_mode = G_IDLE; nxt_double = 1; end
            G_HELD:
               if (fq) g_mode = G_IDLE;
               else if (REPEAT_EN && ((n - g_t0) % R == 0)) nxt_repeat = 1;
            default: g_mode = G_IDLE;
         endcase
      end
      nxt_held = (g_mode == G_HELD);
      nxt_busy = (g_mode != G_IDLE);
   endtask

   int  short_log[$], double_log[$], long_log[$], repeat_log[$], held_rise_log[$], held_fall_log[$];
   int  busy_cnt = 0;
   bit  prev_held = 0;

   always @(negedge clk) begin
      check("short",   int'(o_short_press),  int'(exp_short));
      check("double",  int'(o_double_press), int'(exp_double));
      check("long",    int'(o_long_press),   int'(exp_long));
      check("held",    int'(o_held),         int'(exp_held));
      check("repeat",  int'(o_repeat),       int'(exp_repeat));
      check("busy",    int'(o_busy),         int'(exp_busy));
      check("exclusive", int'(int'(o_short_press) + int'(o_double_press) + int'(o_long_press) <= 1), 1);
      if (o_short_press)  short_log.push_back(cyc);
      if (o_double_press) double_log.push_back(cyc);
      if (o_long_press)   long_log.push_back(cyc);
      if (o_repeat)       repeat_log.push_back(cyc);
      if (o_held && !prev_held) held_rise_log.push_back(cyc);
      if (!o_held && prev_held) held_fall_log.push_back(cyc);
      if (o_busy) busy_cnt++;
      prev_held = o_held;
   end

   task automatic clear_logs();
      short_log.delete(); double_log.delete(); long_log.delete(); repeat_log.delete();
      held_rise_log.delete(); held_fall_log.delete();
      busy_cnt = 0;
   endtask

   // Drive one cycle of input; reset acts immediately on the outputs.
   task automatic step(input bit r, input bit f, input bit rv);
      ctrl.rising  = r;
      ctrl.falling = f;
      rst_n        = rv;
      model_cycle(r, f, rv, cyc);
      if (!rv) begin
         exp_short = 0; exp_double = 0; exp_long = 0; exp_held = 0; exp_repeat = 0; exp_busy = 0;
      end
      @(posedge clk);
      cyc++;
      #1;
      exp_short = nxt_short; exp_double = nxt_double; exp_long = nxt_long;
      exp_held = nxt_held; exp_repeat = nxt_repeat; exp_busy = nxt_busy;
   endtask

   task automatic idle_to(input int t);
      while (cyc < t) step(0, 0, 1);
   endtask

   task automatic do_at(input int t, input bit r, input bit f);
      idle_to(t);
      step(r, f, 1);
   endtask

   task automatic check_q(input string name, input int q[$], input int e[$]);
      check({name, "_count"}, q.size(), e.size());
      for (int i = 0; i < q.size() && i < e.size(); i++) check(name, q[i], e[i]);
   endtask

   int b;
   int empty_q[$];

   initial begin
      ctrl  = '0;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      check("reset_busy", int'(o_busy), 0);
      check("reset_held", int'(o_held), 0);

      // Short press
      clear_logs(); b = cyc;
      do_at(b + 10, 1, 0); do_at(b + 60, 0, 1); idle_to(b + 400);
      check_q("s1_short", short_log, '{b + 361});
      check_q("s1_double", double_log, empty_q);
      check_q("s1_long", long_log, empty_q);

      // Double press
      clear_logs(); b = cyc;
      do_at(b + 10, 1, 0); do_at(b + 60, 0, 1); do_at(b + 200, 1, 0); do_at(b + 250, 0, 1);
      idle_to(b + 700);
      check_q("s2_double", double_log, '{b + 251});
      check_q("s2_short", short_log, empty_q);

      // Long press with optional auto-repeat
      clear_logs(); b = cyc;
      do_at(b + 10, 1, 0); do_at(b + 1500, 0, 1); idle_to(b + 1700);
      check_q("s3_long", long_log, '{b + 1011});
      check_q("s3_held_rise", held_rise_log, '{b + 1011});
      check_q("s3_held_fall", held_fall_log, '{b + 1501});
      check_q("s3_short", short_log, empty_q);
      check_q("s3_double", double_log, empty_q);
      if (REPEAT_EN) check_q("s4_repeat", repeat_log, '{b + 1211, b + 1411});
      else           check_q("s4_repeat", repeat_log, empty_q);

      // Reset mid-gesture
      clear_logs(); b = cyc;
      do_at(b + 10, 1, 0); do_at(b + 60, 0, 1); idle_to(b + 200);
      step(0, 0, 0);
      check("s5_busy_in_reset", int'(o_busy), 0);
      step(0, 0, 0); step(0, 0, 0);
      do_at(b + 400, 1, 0); do_at(b + 450, 0, 1); idle_to(b + 800);
      check_q("s5_short", short_log, '{b + 751});
      check_q("s5_double", double_log, empty_q);

      // Coincident edges in IDLE
      clear_logs(); b = cyc;
      do_at(b + 10, 1, 1); idle_to(b + 30);
      check("s6_same_cycle_busy", busy_cnt, 0);

      // Rising exactly at the gap limit
      clear_logs(); b = cyc;
      do_at(b + 10, 1, 0); do_at(b + 60, 0, 1); do_at(b + 360, 1, 0); do_at(b + 400, 0, 1);
      idle_to(b + 800);
      check_q("s6_gap_double", double_log, '{b + 401});
      check_q("s6_gap_short", short_log, empty_q);

      // Randomized gestures around the thresholds, with stray edges and occasional resets
      for (int g = 0; g < 20; g++) begin
         int p, gap;
         case ($urandom_range(0, 3))
            0:       p = $urandom_range(1, 40);
            1:       p = $urandom_range(L - 2, L + 2);
            2:       p = $urandom_range(L + 1, L + 450);
            default: p = $urandom_range(1, 4);
         endcase
         case ($urandom_range(0, 2))
            0:       gap = $urandom_range(1, 60);
            1:       gap = $urandom_range(G - 2, G + 2);
            default: gap = $urandom_range(G + 1, G + 40);
         endcase
         step(1, 0, 1);
         for (int k = 1; k < p; k++) begin
            int sel;
            sel = $urandom_range(0, 63);
            step(sel == 0 || sel == 1, sel == 0, 1);
         end
         step(0, 1, 1);
         for (int k = 1; k < gap; k++) begin
            int sel;
            sel = $urandom_range(0, 63);
            step(sel == 0, sel == 0 || sel == 1, sel != 2);
         end
      end
      idle_to(cyc + 2 * L);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
